// File: rtl/ssp_arb_pkg.sv
// Shared constants, state encoding and helpers for the SSP register-port arbiter.
package ssp_arb_pkg;

  localparam int unsigned DATA_W = 12;
  localparam int unsigned ADDR_W = 3;

  localparam logic [ADDR_W-1:0] UCR = 3'd0;
  localparam logic [ADDR_W-1:0] USR = 3'd1;
  localparam logic [ADDR_W-1:0] RDR = 3'd2;
  localparam logic [ADDR_W-1:0] TDR = 3'd3;
  localparam logic [ADDR_W-1:0] SPR = 3'd4;
  localparam logic [ADDR_W-1:0] RA_MAX = SPR;

  localparam logic [DATA_W-1:0] UCR_RST = 12'h000;
  localparam logic [DATA_W-1:0] USR_RST = 12'h000;
  localparam logic [DATA_W-1:0] RDR_RST = 12'h000;
  localparam logic [DATA_W-1:0] TDR_RST = 12'h000;
  localparam logic [DATA_W-1:0] SPR_RST = 12'h000;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StWait,
    StDone,
    StErr
  } arb_state_t;

  function automatic logic ra_legal(input logic [ADDR_W-1:0] ra);
    return ra <= RA_MAX;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after the pointer.
module rr_arbiter #(
  parameter int unsigned N_REQ = 2,
  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IdxW-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IdxW-1:0]  idx_o
);

  always_comb begin
    int unsigned cand;
    logic        found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = (int'(ptr_i) + i) % N_REQ;
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/ssp_reg_arbiter.sv
// Serialises single register accesses from N_REQ requesters onto the ssp_uart SSP port.
module ssp_reg_arbiter
  import ssp_arb_pkg::*;
#(
  parameter int unsigned N_REQ    = 2,
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic                           Clk,
  input  logic                           Rst_n,
  input  logic [N_REQ-1:0]               Req,
  input  logic [N_REQ-1:0][ADDR_W-1:0]   Req_RA,
  input  logic [N_REQ-1:0]               Req_WnR,
  input  logic [N_REQ-1:0][DATA_W-1:0]   Req_DI,
  output logic [N_REQ-1:0]               Gnt,
  output logic [N_REQ-1:0]               Ack,
  output logic                           Err,
  output logic [DATA_W-1:0]              Rd_Data,
  output logic                           Busy,
  output logic                           SSP_SSEL,
  output logic                           SSP_EOC,
  output logic [ADDR_W-1:0]              SSP_RA,
  output logic                           SSP_WnR,
  output logic [DATA_W-1:0]              SSP_DI,
  input  logic [DATA_W-1:0]              SSP_DO
);

  localparam int unsigned     IdxW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(N_REQ - 1);
  localparam logic [2:0]      WaitLoad = 3'(WAIT_CYC - 1);

  arb_state_t         state_q;
  logic [IdxW-1:0]    ptr_q;
  logic [IdxW-1:0]    idx_q;
  logic [2:0]         wait_cnt_q;
  logic [N_REQ-1:0]   gnt_q;
  logic [N_REQ-1:0]   ack_q;
  logic               err_q;
  logic [DATA_W-1:0]  rd_data_q;
  logic               busy_q;
  logic               ssel_q;
  logic               eoc_q;
  logic [ADDR_W-1:0]  ra_q;
  logic               wnr_q;
  logic [DATA_W-1:0]  di_q;

  logic [N_REQ-1:0]   pick_gnt;
  logic [IdxW-1:0]    pick_idx;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr_arbiter (
    .req_i (Req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      idx_q      <= '0;
      wait_cnt_q <= '0;
      gnt_q      <= '0;
      ack_q      <= '0;
      err_q      <= 1'b0;
      rd_data_q  <= '0;
      busy_q     <= 1'b0;
      ssel_q     <= 1'b0;
      eoc_q      <= 1'b0;
      ra_q       <= '0;
      wnr_q      <= 1'b0;
      di_q       <= '0;
    end else begin
      ack_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (|Req) begin
            gnt_q  <= pick_gnt;
            idx_q  <= pick_idx;
            busy_q <= 1'b1;
            if (ra_legal(Req_RA[pick_idx])) begin
              state_q <= StSetup;
              ssel_q  <= 1'b1;
              ra_q    <= Req_RA[pick_idx];
              wnr_q   <= Req_WnR[pick_idx];
              di_q    <= Req_DI[pick_idx];
            end else begin
              // Illegal address: acknowledge with error, SSP port stays quiet.
              state_q   <= StErr;
              ack_q     <= pick_gnt;
              err_q     <= 1'b1;
              rd_data_q <= '0;
            end
          end
        end
        StSetup: begin
          eoc_q   <= 1'b1;
          state_q <= StStrobe;
        end
        StStrobe: begin
          eoc_q      <= 1'b0;
          wait_cnt_q <= WaitLoad;
          state_q    <= StWait;
        end
        StWait: begin
          if (wait_cnt_q == 3'd0) begin
            rd_data_q <= wnr_q ? '0 : SSP_DO;
            ssel_q    <= 1'b0;
            ra_q      <= '0;
            wnr_q     <= 1'b0;
            di_q      <= '0;
            ack_q     <= gnt_q;
            err_q     <= 1'b0;
            state_q   <= StDone;
          end else begin
            wait_cnt_q <= wait_cnt_q - 3'd1;
          end
        end
        StDone, StErr: begin
          gnt_q     <= '0;
          err_q     <= 1'b0;
          rd_data_q <= '0;
          busy_q    <= 1'b0;
          ptr_q     <= (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign Gnt      = gnt_q;
  assign Ack      = ack_q;
  assign Err      = err_q;
  assign Rd_Data  = rd_data_q;
  assign Busy     = busy_q;
  assign SSP_SSEL = ssel_q;
  assign SSP_EOC  = eoc_q;
  assign SSP_RA   = ra_q;
  assign SSP_WnR  = wnr_q;
  assign SSP_DI   = di_q;

endmodule

// File: tb/tb_ssp_reg_arbiter.sv
// Directed bench for ssp_reg_arbiter with a simple register-file model of ssp_uart.
module tb_ssp_reg_arbiter;
  import ssp_arb_pkg::*;

  localparam int unsigned NR = 2;
  localparam int unsigned W  = 1;

  logic                   Clk;
  logic                   Rst_n;
  logic [NR-1:0]          Req;
  logic [NR-1:0][2:0]     Req_RA;
  logic [NR-1:0]          Req_WnR;
  logic [NR-1:0][11:0]    Req_DI;
  logic [NR-1:0]          Gnt;
  logic [NR-1:0]          Ack;
  logic                   Err;
  logic [11:0]            Rd_Data;
  logic                   Busy;
  logic                   SSP_SSEL;
  logic                   SSP_EOC;
  logic [2:0]             SSP_RA;
  logic                   SSP_WnR;
  logic [11:0]            SSP_DI;
  logic [11:0]            SSP_DO;

  ssp_reg_arbiter #(
    .N_REQ    (NR),
    .WAIT_CYC (W)
  ) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Req      (Req),
    .Req_RA   (Req_RA),
    .Req_WnR  (Req_WnR),
    .Req_DI   (Req_DI),
    .Gnt      (Gnt),
    .Ack      (Ack),
    .Err      (Err),
    .Rd_Data  (Rd_Data),
    .Busy     (Busy),
    .SSP_SSEL (SSP_SSEL),
    .SSP_EOC  (SSP_EOC),
    .SSP_RA   (SSP_RA),
    .SSP_WnR  (SSP_WnR),
    .SSP_DI   (SSP_DI),
    .SSP_DO   (SSP_DO)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Register-file stand-in for ssp_uart: writes on the EOC strobe, reads combinationally.
  logic [11:0] mem [8] = '{UCR_RST, USR_RST, RDR_RST, TDR_RST, SPR_RST, 12'h0, 12'h0, 12'h0};
  always @(posedge Clk) if (SSP_SSEL && SSP_EOC && SSP_WnR) mem[SSP_RA] <= SSP_DI;
  assign SSP_DO = SSP_SSEL ? mem[SSP_RA] : 12'h000;

  int eoc_bad = 0;
  int gnt_bad = 0;
  int gnt0_cyc = 0;
  int ack_cnt [NR] = '{0, 0};
  always @(negedge Clk) begin
    if (SSP_EOC && !SSP_SSEL) eoc_bad++;
    if ($countones(Gnt) > 1) gnt_bad++;
    if (Gnt[0]) gnt0_cyc++;
    for (int i = 0; i < NR; i++) if (Ack[i]) ack_cnt[i]++;
  end

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({Gnt, Ack, Err, Rd_Data, Busy, SSP_SSEL, SSP_EOC, SSP_RA, SSP_WnR, SSP_DI});
  endfunction

  task automatic do_txn(input int id, input logic [2:0] ra, input logic wnr, input logic [11:0] di,
                        output logic got_ack, output logic err, output logic [11:0] rd,
                        output int lat, output int ssel_n, output int eoc_n, output int eoc_pos,
                        output logic gnt_ok, output int ack_cyc, output logic idle_ok);
    logic [NR-1:0] exp_g;
    logic          seen;
    exp_g = '0;
    exp_g[id] = 1'b1;
    Req_RA[id] = ra;
    Req_WnR[id] = wnr;
    Req_DI[id] = di;
    Req[id] = 1'b1;
    got_ack = 1'b0; err = 1'b0; rd = '0; lat = 0; ssel_n = 0; eoc_n = 0; eoc_pos = 0;
    gnt_ok = 1'b1; ack_cyc = 0; seen = 1'b0;
    for (int t = 1; t <= 20 && !seen; t++) begin
      tick();
      if (SSP_SSEL) ssel_n++;
      if (SSP_EOC) begin
        eoc_n++;
        eoc_pos = t;
      end
      if (Gnt != exp_g) gnt_ok = 1'b0;
      if (Ack != '0) begin
        seen = 1'b1;
        got_ack = (Ack == exp_g);
        err = Err;
        rd = Rd_Data;
        lat = t;
        ack_cyc = cyc;
      end
    end
    Req[id] = 1'b0;
    tick();
    idle_ok = (Ack == '0) && (Gnt == '0) && !Busy && !SSP_SSEL;
  endtask

  typedef struct {
    int          id;
    logic [2:0]  ra;
    logic        wnr;
    logic [11:0] di;
    logic        exp_err;
    logic [11:0] exp_rd;
  } vec_t;

  vec_t vecs [13];

  initial begin
    logic        got, e, gok, iok;
    logic [11:0] rd;
    int          lat, sn, en, ep, ack_c, prev_ack, a0, k;
    int          ord [8];
    logic [11:0] ord_rd [8];

    Rst_n = 1'b0;
    Req = '0;
    Req_RA = '0;
    Req_WnR = '0;
    Req_DI = '0;

    vecs[0]  = '{1, UCR,  1'b0, 12'h000, 1'b0, 12'h000};
    vecs[1]  = '{1, USR,  1'b0, 12'h000, 1'b0, 12'h000};
    vecs[2]  = '{1, RDR,  1'b0, 12'h000, 1'b0, 12'h000};
    vecs[3]  = '{1, TDR,  1'b0, 12'h000, 1'b0, 12'h000};
    vecs[4]  = '{1, SPR,  1'b0, 12'h000, 1'b0, 12'h000};
    vecs[5]  = '{0, UCR,  1'b1, 12'hDED, 1'b0, 12'h000};
    vecs[6]  = '{0, UCR,  1'b0, 12'h000, 1'b0, 12'hDED};
    vecs[7]  = '{1, SPR,  1'b1, 12'h123, 1'b0, 12'h000};
    vecs[8]  = '{1, SPR,  1'b0, 12'h000, 1'b0, 12'h123};
    vecs[9]  = '{0, 3'd5, 1'b0, 12'h000, 1'b1, 12'h000};
    vecs[10] = '{1, 3'd7, 1'b1, 12'hFFF, 1'b1, 12'h000};
    vecs[11] = '{0, TDR,  1'b0, 12'h000, 1'b0, 12'h000};
    vecs[12] = '{1, UCR,  1'b0, 12'h000, 1'b0, 12'hDED};

    // Reset state
    tick();
    check("reset_outs", all_outs(), 64'h0);
    Rst_n = 1'b1;
    tick();
    check("idle_outs", all_outs(), 64'h0);

    prev_ack = 0;
    for (int i = 0; i < 13; i++) begin
      do_txn(vecs[i].id, vecs[i].ra, vecs[i].wnr, vecs[i].di, got, e, rd, lat, sn, en, ep, gok,
             ack_c, iok);
      check($sformatf("v%0d_ack", i), 64'(got), 64'(1'b1));
      check($sformatf("v%0d_err", i), 64'(e), 64'(vecs[i].exp_err));
      check($sformatf("v%0d_rd", i), 64'(rd), 64'(vecs[i].exp_rd));
      check($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].exp_err ? 1 : 3 + W));
      check($sformatf("v%0d_ssel", i), 64'(sn), 64'(vecs[i].exp_err ? 0 : 2 + W));
      check($sformatf("v%0d_eoc", i), 64'(en), 64'(vecs[i].exp_err ? 0 : 1));
      check($sformatf("v%0d_eocpos", i), 64'(ep), 64'(vecs[i].exp_err ? 0 : 2));
      check($sformatf("v%0d_gnt", i), 64'(gok), 64'(1'b1));
      check($sformatf("v%0d_idle", i), 64'(iok), 64'(1'b1));
      if (i >= 1 && i <= 4) check($sformatf("v%0d_space", i), 64'(ack_c - prev_ack), 64'(4 + W));
      prev_ack = ack_c;
    end
    check("no_write_illegal", 64'(mem[7]), 64'h0);

    // Contention: both request continuously, pointer is at 0 after requester 1's last ack.
    Req_RA[0] = TDR; Req_WnR[0] = 1'b1; Req_DI[0] = 12'h0A5;
    Req_RA[1] = USR; Req_WnR[1] = 1'b0; Req_DI[1] = 12'h000;
    Req = 2'b11;
    k = 0;
    for (int t = 0; t < 4 * (4 + W); t++) begin
      tick();
      if (Ack != '0 && k < 8) begin
        ord[k] = Ack[1] ? 1 : 0;
        ord_rd[k] = Rd_Data;
        k++;
      end
    end
    Req = '0;
    tick();
    tick();
    check("cont_count", 64'(k), 64'd4);
    for (int j = 0; j < 4 && j < k; j++) begin
      check($sformatf("cont_ord%0d", j), 64'(ord[j]), 64'(j % 2));
      check($sformatf("cont_rd%0d", j), 64'(ord_rd[j]), 64'h0);
    end
    check("cont_tdr", 64'(mem[3]), 64'h0A5);
    check("gnt_onehot", 64'(gnt_bad), 64'h0);

    // Reset during STROBE
    Req_RA[0] = RDR; Req_WnR[0] = 1'b0;
    Req = 2'b01;
    tick();
    tick();
    check("rst_in_strobe", 64'(SSP_EOC), 64'h1);
    a0 = ack_cnt[0];
    #2 Rst_n = 1'b0;
    #1;
    check("rst_async_outs", all_outs(), 64'h0);
    Req = '0;
    tick();
    tick();
    check("rst_no_ack", 64'(ack_cnt[0] - a0), 64'h0);
    Rst_n = 1'b1;
    Req_RA[1] = USR; Req_WnR[1] = 1'b0;
    Req = 2'b10;
    tick();
    check("rst_regrant", 64'(Gnt), 64'(2'b10));
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      tick();
      if (Ack[1]) got = 1'b1;
    end
    check("rst_regrant_ack", 64'(got), 64'h1);
    Req = '0;
    tick();

    // Withdrawn request from requester 0 while requester 1 is busy
    a0 = ack_cnt[0];
    gnt0_cyc = 0;
    Req_RA[1] = SPR; Req_WnR[1] = 1'b0;
    Req = 2'b10;
    tick();
    check("wd_busy", 64'(Busy), 64'h1);
    Req_RA[0] = UCR; Req_WnR[0] = 1'b1; Req_DI[0] = 12'h555;
    Req[0] = 1'b1;
    tick();
    tick();
    Req[0] = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      tick();
      if (Ack[1]) got = 1'b1;
    end
    check("wd_r1_ack", 64'(got), 64'h1);
    Req = '0;
    for (int t = 0; t < 8; t++) tick();
    check("wd_no_gnt0", 64'(gnt0_cyc), 64'h0);
    check("wd_no_ack0", 64'(ack_cnt[0] - a0), 64'h0);
    check("wd_ucr_kept", 64'(mem[0]), 64'hDED);
    check("eoc_within_ssel", 64'(eoc_bad), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
